// File: rtl/StateDefs.sv
// Shared type definitions for the datapath and its controller.
package StateDefs;

  localparam int unsigned RF_DEPTH    = 16;
  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned ALU_OP_W    = 3;

  // Instruction opcodes decoded by the controller.
  typedef enum logic [3:0] {
    INST_NOP   = 4'd0,
    INST_LOAD  = 4'd1,
    INST_STORE = 4'd2,
    INST_ADD   = 4'd3,
    INST_SUB   = 4'd4,
    INST_AND   = 4'd5,
    INST_OR    = 4'd6,
    INST_XOR   = 4'd7,
    INST_NOT   = 4'd8,
    INST_MOV   = 4'd9,
    INST_HALT  = 4'd15
  } inst_t;

  // Controller sequencing states; Load_A/Load_B cover the two-cycle memory load.
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD_A = 3'd3,
    S_LOAD_B = 3'd4,
    S_STORE  = 3'd5,
    S_ALU    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // ALU operation select as driven on Alu_s0.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS_A = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_NOT_A  = 3'd6,
    ALU_ZERO   = 3'd7
  } alu_op_t;

endpackage

// File: rtl/register_file.sv
// 16-entry register file: two combinational read ports, one synchronous write port.
module register_file
  import StateDefs::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 W_en,
  input  logic [RF_ADDR_W-1:0] W_addr,
  input  logic [DATA_W-1:0]    W_data,
  input  logic [RF_ADDR_W-1:0] Ra_addr,
  input  logic [RF_ADDR_W-1:0] Rb_addr,
  output logic [DATA_W-1:0]    Ra_data,
  output logic [DATA_W-1:0]    Rb_data
);

  logic [DATA_W-1:0] r_regs [RF_DEPTH];

  // Clear all entries in reset; otherwise write on enable (reads see old value until the edge).
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (W_en) begin
      r_regs[W_addr] <= W_data;
    end
  end

  assign Ra_data = r_regs[Ra_addr];
  assign Rb_data = r_regs[Rb_addr];

endmodule

// File: rtl/datapath_unit.sv
// Datapath: register file, inline ALU and data memory with registered read data.
module datapath_unit
  import StateDefs::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic                   Clk,
  input  logic                   ResetN,
  input  logic [DMEM_ADDR_W-1:0] D_addr,
  input  logic                   D_wr,
  input  logic                   RF_s,
  input  logic                   RF_W_en,
  input  logic [RF_ADDR_W-1:0]   RF_W_addr,
  input  logic [RF_ADDR_W-1:0]   RF_Ra_addr,
  input  logic [RF_ADDR_W-1:0]   RF_Rb_addr,
  input  logic [ALU_OP_W-1:0]    Alu_s0,
  output logic [DATA_W-1:0]      Ra_data,
  output logic [DATA_W-1:0]      Rb_data,
  output logic [DATA_W-1:0]      Mem_q,
  output logic [DATA_W-1:0]      Alu_out,
  output logic [DATA_W-1:0]      W_data,
  output logic                   Alu_zero
);

  localparam int unsigned MEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DMEM_DEPTH];
  logic [DATA_W-1:0] r_mem_q;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_alu;
  alu_op_t           w_alu_op;

  register_file #(
    .DATA_W (DATA_W)
  ) u_register_file (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .W_en    (RF_W_en),
    .W_addr  (RF_W_addr),
    .W_data  (W_data),
    .Ra_addr (RF_Ra_addr),
    .Rb_addr (RF_Rb_addr),
    .Ra_data (Ra_data),
    .Rb_data (Rb_data)
  );

  // Addresses beyond the memory size wrap around.
  assign w_mem_addr = MEM_AW'(32'(D_addr) % DMEM_DEPTH);

  assign w_alu_op = alu_op_t'(Alu_s0);

  // ALU: modulo-2^DATA_W arithmetic, no carry out.
  always_comb begin
    w_alu = '0;
    case (w_alu_op)
      ALU_PASS_A: w_alu = Ra_data;
      ALU_ADD:    w_alu = Ra_data + Rb_data;
      ALU_SUB:    w_alu = Ra_data - Rb_data;
      ALU_AND:    w_alu = Ra_data & Rb_data;
      ALU_OR:     w_alu = Ra_data | Rb_data;
      ALU_XOR:    w_alu = Ra_data ^ Rb_data;
      ALU_NOT_A:  w_alu = ~Ra_data;
      ALU_ZERO:   w_alu = '0;
      default:    w_alu = '0;
    endcase
  end

  // Memory array write; contents are deliberately not touched by reset.
  always_ff @(posedge Clk) begin
    if (ResetN && D_wr) begin
      r_mem[w_mem_addr] <= Ra_data;
    end
  end

  // One-cycle registered read; same-edge write is not visible (read-before-write).
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_mem_q <= '0;
    end else begin
      r_mem_q <= r_mem[w_mem_addr];
    end
  end

  assign Mem_q    = r_mem_q;
  assign Alu_out  = w_alu;
  assign Alu_zero = (w_alu == '0);
  assign W_data   = RF_s ? r_mem_q : w_alu;

endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 16, giving the datapath word width.
REQ-002 The block SHALL have a parameter DMEM_DEPTH, default 256, giving the data memory word count, addressed by D_addr.
REQ-003 Clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 ResetN  input  1  reset; synchronous, active-low.
REQ-005 D_addr  input  8  data memory address.
REQ-006 D_wr  input  1  data memory write strobe.
REQ-007 RF_s  input  1  RF write-data select: 1 = memory read data, 0 = ALU result.
REQ-008 RF_W_en  input  1  register file write enable.
REQ-009 RF_W_addr, RF_Ra_addr, RF_Rb_addr  input  4 each  RF write, read-A and read-B addresses.
REQ-010 Alu_s0  input  3  ALU operation select.
REQ-011 Ra_data, Rb_data  output  DATA_W each  combinational RF read ports A and B.
REQ-012 Mem_q  output  DATA_W  registered data memory read data.
REQ-013 Alu_out  output  DATA_W  combinational ALU result.
REQ-014 W_data  output  DATA_W  RF write data after the RF_s mux.
REQ-015 Alu_zero  output  1  high when Alu_out equals 0.

Function
REQ-016 Register file: 16 x DATA_W; reads combinational; write on rising Clk when RF_W_en=1, storing W_data at RF_W_addr.
REQ-017 Read/write same RF address in one cycle: the read port SHALL show the old value until the edge, then the new value.
REQ-018 Data memory: DMEM_DEPTH x DATA_W; write on rising Clk when D_wr=1, storing Ra_data at D_addr.
REQ-019 Mem_q SHALL load mem[D_addr] every rising Clk, giving a read latency of exactly one cycle; this matches the Load_A/Load_B two-state sequence.
REQ-020 D_wr with a read of the same address in one cycle: Mem_q SHALL capture the old contents (read-before-write).
REQ-021 D_wr and RF_W_en asserted together SHALL both take effect in the same edge.
REQ-022 ALU ops by Alu_s0:
- 0 = pass A
- 1 = A+B
- 2 = A-B
- 3 = A&B
- 4 = A|B
- 5 = A^B
- 6 = ~A
- 7 = 0
REQ-023 Add and subtract SHALL be modulo 2^DATA_W; wrap-around SHALL NOT be flagged and no carry output exists.
REQ-024 ALU operand A SHALL be Ra_data and operand B SHALL be Rb_data.
REQ-025 W_data SHALL be Mem_q when RF_s=1, otherwise Alu_out.
REQ-026 Out-of-range D_addr (DMEM_DEPTH < 256) SHALL wrap modulo DMEM_DEPTH.

Reset
REQ-027 While ResetN=0 at a rising Clk, all 16 RF entries SHALL clear to 0 and Mem_q SHALL clear to 0.
REQ-028 While ResetN=0, RF and memory writes SHALL be suppressed.
REQ-029 Data memory contents SHALL be unaffected by reset.
REQ-030 Reset asserted between Load_A and Load_B SHALL abort the load; no RF write SHALL occur on that edge.
REQ-031 After reset release, the first edge SHALL behave normally.

Structure
REQ-032 The ALU op encoding SHALL be an enum in the shared StateDefs package, alongside the existing inst and State enums.
REQ-033 The register file SHALL be a sub-module named register_file.
REQ-034 The ALU and data memory SHALL be inline in datapath_unit.

Verification
REQ-035 Reset: hold ResetN=0 for 2 edges -> Ra_data=Rb_data=0 for all addresses, Mem_q=0.
REQ-036 Preload mem[0x10]=0x0007, then D_addr=0x10, RF_s=1, RF_W_addr=3 for 2 cycles with RF_W_en=1 on the second -> R3=0x0007.
REQ-037 R1=0x0005, R2=0x0003:
- Alu_s0=1, RF_W_addr=4, RF_W_en=1 -> R4=0x0008.
- Alu_s0=2 -> 0x0002, Alu_zero=0.
REQ-038 R1=0x0000, R2=0x0001, Alu_s0=2 -> Alu_out=0xFFFF.
REQ-039 R1=0xFFFF, R2=0x0001, Alu_s0=1 -> Alu_out=0x0000, Alu_zero=1.
REQ-040 Store: RF_Ra_addr=4 (R4=0x0008), D_addr=0x20, D_wr=1 -> next cycle read of 0x20 gives Mem_q=0x0008.
REQ-041 Same-cycle store and read of 0x20 -> Mem_q shows the prior value.
REQ-042 ResetN=0 on the Load_B cycle -> target register stays 0.
